// File: rtl/dpcm_predictor_stream.sv
// Streaming lossless-DPCM predictor: raster pixels in, signed prediction errors out.
// Keeps one previous-row line buffer plus left/upper-left neighbours; four selectable predictors.
module dpcm_predictor_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int COL_W = 9,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W:0]   out_error,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first_row,
    output logic             out_first_col,
    output logic             out_last
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [PIX_W-1:0] left;
    logic [PIX_W-1:0] ul;
    logic [1:0]       mode_q;
    logic [PIX_W-1:0] linebuf [IMG_W];

    logic                    accept;
    logic                    first_row;
    logic                    first_col;
    logic                    col_last;
    logic                    row_last;
    logic [1:0]              mode_eff;
    logic [PIX_W-1:0]        top;
    logic [PIX_W-1:0]        pred;
    logic signed [PIX_W:0]   err;

    // Edge rules take priority over the frame mode, so the line buffer is only read once row 0 has filled it.
    function automatic logic [PIX_W-1:0] predict(
        input logic [1:0]       md,
        input logic             r0,
        input logic             c0,
        input logic [PIX_W-1:0] l,
        input logic [PIX_W-1:0] t,
        input logic [PIX_W-1:0] u
    );
        logic [PIX_W-1:0] mx;
        logic [PIX_W-1:0] mn;
        logic [PIX_W:0]   sum;
        logic [PIX_W:0]   grad;
        logic [PIX_W-1:0] p;
        mx   = (l > t) ? l : t;
        mn   = (l > t) ? t : l;
        sum  = {1'b0, l} + {1'b0, t};
        grad = {1'b0, l} + {1'b0, t} - {1'b0, u};
        p    = '0;
        if (r0 && c0) begin
            p = '0;
        end else if (r0) begin
            p = l;
        end else if (c0) begin
            p = t;
        end else begin
            case (md)
                2'd0: p = l;
                2'd1: p = t;
                2'd2: p = PIX_W'(sum >> 1);
                default: begin
                    // Gradient term only reached when UL lies strictly between L and T, so it cannot leave range.
                    if (u >= mx)      p = mn;
                    else if (u <= mn) p = mx;
                    else              p = PIX_W'(grad);
                end
            endcase
        end
        return p;
    endfunction

    function automatic logic signed [PIX_W:0] residual(
        input logic [PIX_W-1:0] pix,
        input logic [PIX_W-1:0] p
    );
        return $signed({1'b0, pix}) - $signed({1'b0, p});
    endfunction

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign first_row = (row == '0);
    assign first_col = (col == '0);
    assign col_last  = (col == COL_W'(IMG_W - 1));
    assign row_last  = (row == ROW_W'(IMG_H - 1));
    assign mode_eff  = (first_row && first_col) ? mode : mode_q;
    assign top       = linebuf[col];
    assign pred      = predict(mode_eff, first_row, first_col, left, top, ul);
    assign err       = residual(in_pixel, pred);

    // Stage boundary: accept -> registered error/flags, neighbour and counter update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_error     <= '0;
            out_first_row <= 1'b0;
            out_first_col <= 1'b0;
            out_last      <= 1'b0;
            row           <= '0;
            col           <= '0;
            left          <= '0;
            ul            <= '0;
            mode_q        <= 2'd0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_error     <= err;
            out_first_row <= first_row;
            out_first_col <= first_col;
            out_last      <= row_last && col_last;
            left          <= in_pixel;
            ul            <= top;
            if (first_row && first_col) begin
                mode_q <= mode;
            end
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Line buffer holds pure data; entries are always rewritten before row>0 reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf[col] <= in_pixel;
        end
    end

endmodule

// File: tb/tb_dpcm_predictor_stream.sv
// Scoreboard bench for dpcm_predictor_stream: image-array reference model feeds an expected queue,
// an independent monitor pops and compares on every presented output.
module tb_dpcm_predictor_stream;

    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int NPIX  = IMG_W * IMG_H;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [PIX_W-1:0] in_pixel = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PIX_W:0]   out_error;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_first_row;
    logic             out_first_col;
    logic             out_last;

    dpcm_predictor_stream #(
        .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .COL_W(2), .ROW_W(2)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_ready(in_ready), .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready),
        .out_first_row(out_first_row), .out_first_col(out_first_col), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int err;
        int fr;
        int fc;
        int last;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random backpressure, 2: held low
    int img [IMG_H][IMG_W];
    int m_row = 0;
    int m_col = 0;
    int m_mode = 0;
    int frame_px [NPIX];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: prediction from the frame image itself, by position.
    task automatic model_accept(input int pix, input int md);
        int l, t, u, p, mx, mn;
        exp_t e;
        if (m_row == 0 && m_col == 0) m_mode = md;
        l = (m_col > 0) ? img[m_row][m_col-1] : 0;
        t = (m_row > 0) ? img[m_row-1][m_col] : 0;
        u = (m_row > 0 && m_col > 0) ? img[m_row-1][m_col-1] : 0;
        mx = (l > t) ? l : t;
        mn = (l > t) ? t : l;
        if (m_row == 0 && m_col == 0)  p = 0;
        else if (m_row == 0)           p = l;
        else if (m_col == 0)           p = t;
        else if (m_mode == 0)          p = l;
        else if (m_mode == 1)          p = t;
        else if (m_mode == 2)          p = (l + t) / 2;
        else if (u >= mx)              p = mn;
        else if (u <= mn)              p = mx;
        else                           p = l + t - u;
        e.err  = pix - p;
        e.fr   = (m_row == 0) ? 1 : 0;
        e.fc   = (m_col == 0) ? 1 : 0;
        e.last = (m_row == IMG_H - 1 && m_col == IMG_W - 1) ? 1 : 0;
        sb.push_back(e);
        img[m_row][m_col] = pix;
        if (m_col == IMG_W - 1) begin
            m_col = 0;
            m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input int pix, input int md);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        in_pixel = PIX_W'(pix);
        mode = 2'(md);
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(pix, md);
                done = 1'b1;
            end else if (++t > 100) begin
                chk("send_timeout", 0, 1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int md, input int gaps);
        for (int i = 0; i < NPIX; i++) begin
            send(frame_px[i], (i == 0) ? md : int'($urandom_range(0, 3)));
            if (gaps != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NPIX; i++) frame_px[i] = int'($urandom_range(0, 255));
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: compare every presented output with the queue head; pop on transfer.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                chk("out_error", int'($signed(out_error)), sb[0].err);
                chk("out_first_row", int'(out_first_row), sb[0].fr);
                chk("out_first_col", int'(out_first_col), sb[0].fc);
                chk("out_last", int'(out_last), sb[0].last);
                if (out_ready) void'(sb.pop_front());
                else chk("stall_in_ready", int'(in_ready), 0);
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_error", int'(out_error), 0);
        chk("rst_first_row", int'(out_first_row), 0);
        chk("rst_first_col", int'(out_first_col), 0);
        chk("rst_out_last", int'(out_last), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Mode 0 left prediction, first row {10,12,15,15}
        rand_frame();
        frame_px[0] = 10; frame_px[1] = 12; frame_px[2] = 15; frame_px[3] = 15;
        send_frame(0, 0);

        // Mode 1 top prediction
        rand_frame();
        frame_px[0] = 10; frame_px[1] = 20; frame_px[2] = 30; frame_px[3] = 40;
        frame_px[4] = 11; frame_px[5] = 22; frame_px[6] = 33; frame_px[7] = 44;
        send_frame(1, 0);

        // MED: UL above max, below min, and between L and T
        for (int k = 0; k < 3; k++) begin
            rand_frame();
            frame_px[0] = (k == 0) ? 120 : (k == 1) ? 30 : 70;
            frame_px[1] = 100;
            frame_px[4] = 50;
            frame_px[5] = 80;
            send_frame(3, 0);
        end

        // Mode 2 extremes: -255 and +255
        rand_frame();
        frame_px[0] = 255; frame_px[1] = 255;
        frame_px[4] = 255; frame_px[5] = 0;
        frame_px[8] = 0;   frame_px[9] = 255;
        send_frame(2, 0);

        // Output stall of 5 cycles right after the first output
        rand_frame();
        fork
            send_frame(int'($urandom_range(0, 3)), 0);
            begin
                int w;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!out_valid && w < 50);
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                rdy_mode = 0;
            end
        join

        // Reset after 6 pixels: pending output dropped, next pixel starts a frame
        repeat (3) @(posedge clk);
        #1;
        rand_frame();
        for (int i = 0; i < 6; i++) send(frame_px[i], 3);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        sb.delete();
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rand_frame();
        frame_px[0] = 77;
        send_frame(1, 0);

        // Random frames with gaps, backpressure and mid-frame mode changes
        rdy_mode = 1;
        for (int f = 0; f < 10; f++) begin
            rand_frame();
            send_frame(int'($urandom_range(0, 3)), 1);
        end

        rdy_mode = 0;
        for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
